// File: rtl/i2c_master_burst.sv
// Burst I2C master: START, address, optional register byte with repeated START,
// then up to 2^LEN_W-1 data bytes, then STOP. Open-drain SCL/SDA with clock stretching.
module i2c_master_burst #(
  parameter int CLK_DIV = 125,  // must be >= 2
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             read_nwrite,
  input  logic             use_reg,
  input  logic [6:0]       addr,
  input  logic [7:0]       reg_addr,
  input  logic [LEN_W-1:0] byte_count,
  input  logic [7:0]       data_i,
  output logic             data_req,
  output logic [7:0]       data_o,
  output logic             data_valid,
  output logic             ready,
  output logic             nack_err,
  inout  wire              SCL,
  inout  wire              SDA
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_RSTART,
    S_TX, S_TX_ACK, S_RX, S_RX_ACK, S_STOP
  } state_t;

  state_t           state_q, state_d, nxt;
  logic [1:0]       ph_q, ph_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d, buf_q, buf_d, reg_q, reg_d, data_o_q, data_o_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rnw_q, rnw_d, use_reg_q, use_reg_d, rs_done_q, rs_done_d;
  logic             ack_q, ack_d, nack_err_q, nack_err_d;
  logic             data_valid_q, data_valid_d, data_req_q, data_req_d;
  logic             scl_low_q, scl_low_d, sda_low_q, sda_low_d;
  logic [1:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic             scl_s, sda_s, hold, tick, nack, nack_set;

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
  // A released SCL that still reads low is a slave stretching the clock.
  assign hold  = !scl_low_q && !scl_s;
  assign tick  = (state_q != S_IDLE) && (qcnt_q == '0) && !hold;
  assign nack  = (ph_q == 2'd2) ? sda_s : ack_q;

  always_comb begin
    nxt = S_STOP;
    case (state_q)
      S_ADDR_ACK:
        if (nack)                        nxt = S_STOP;
        else if (use_reg_q && !rs_done_q) nxt = S_REG;
        else if (cnt_q == '0)             nxt = S_STOP;
        else if (rnw_q)                   nxt = S_RX;
        else                              nxt = S_TX;
      S_REG_ACK:
        if (nack || cnt_q == '0) nxt = S_STOP;
        else if (rnw_q)          nxt = S_RSTART;
        else                     nxt = S_TX;
      S_TX_ACK:
        nxt = (nack || cnt_q == '0) ? S_STOP : S_TX;
      default: nxt = S_STOP;
    endcase
    nack_set = nack && (state_q != S_TX_ACK || cnt_q != '0);
  end

  always_comb begin
    state_d = state_q;  ph_d = ph_q;  qcnt_d = qcnt_q;  bit_d = bit_q;
    sh_d = sh_q;  buf_d = buf_q;  reg_d = reg_q;  addr_d = addr_q;  cnt_d = cnt_q;
    rnw_d = rnw_q;  use_reg_d = use_reg_q;  rs_done_d = rs_done_q;  ack_d = ack_q;
    nack_err_d = nack_err_q;  data_o_d = data_o_q;
    data_valid_d = 1'b0;  data_req_d = 1'b0;
    scl_sync_d = {scl_sync_q[0], SCL};
    sda_sync_d = {sda_sync_q[0], SDA};

    if (state_q == S_IDLE)  qcnt_d = QMAX;
    else if (!hold)         qcnt_d = (qcnt_q == '0) ? QMAX : qcnt_q - QW'(1);
    if (tick)               ph_d = ph_q + 2'd1;
    if (data_req_q)         buf_d = data_i;

    case (state_q)
      S_IDLE:
        if (start) begin
          rnw_d = read_nwrite;  use_reg_d = use_reg;  addr_d = addr;
          reg_d = reg_addr;  cnt_d = byte_count;  nack_err_d = 1'b0;
          rs_done_d = 1'b0;  bit_d = 3'd7;  ph_d = 2'd0;
          sh_d = {addr, use_reg ? 1'b0 : read_nwrite};
          state_d = S_START;
        end
      S_START:  if (tick && ph_q == 2'd3) state_d = S_ADDR;
      S_ADDR, S_REG, S_TX:
        if (tick && ph_q == 2'd3) begin
          bit_d = bit_q - 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            state_d = (state_q == S_ADDR) ? S_ADDR_ACK :
                      (state_q == S_REG)  ? S_REG_ACK  : S_TX_ACK;
            if (state_q == S_TX) cnt_d = cnt_q - LEN_W'(1);
          end
        end
      S_ADDR_ACK, S_REG_ACK, S_TX_ACK: begin
        // Decide at the sampling quarter so data_req leads the byte by a quarter.
        if (tick && ph_q == 2'd2) begin
          ack_d = sda_s;
          data_req_d = (nxt == S_TX);
        end
        if (tick && ph_q == 2'd3) begin
          state_d = nxt;
          if (nack_set)     nack_err_d = 1'b1;
          if (nxt == S_REG) sh_d = reg_q;
          if (nxt == S_TX)  sh_d = buf_q;
        end
      end
      S_RSTART:
        if (tick && ph_q == 2'd3) begin
          state_d = S_ADDR;  sh_d = {addr_q, 1'b1};  rs_done_d = 1'b1;
        end
      S_RX: begin
        if (tick && ph_q == 2'd2) begin
          sh_d = {sh_q[6:0], sda_s};
          if (bit_q == 3'd0) begin
            data_o_d = {sh_q[6:0], sda_s};
            data_valid_d = 1'b1;
          end
        end
        if (tick && ph_q == 2'd3) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            state_d = S_RX_ACK;  cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      S_RX_ACK: if (tick && ph_q == 2'd3) state_d = (cnt_q == '0) ? S_STOP : S_RX;
      S_STOP:   if (tick && ph_q == 2'd3) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // SCL follows the next state; SDA lags one clk so it changes after SCL has fallen.
    scl_low_d = (state_d != S_IDLE) && (state_d != S_START) && !ph_d[1];
    case (state_q)
      S_START, S_RSTART:   sda_low_d = (ph_q == 2'd3);
      S_STOP:              sda_low_d = (ph_q != 2'd3);
      S_ADDR, S_REG, S_TX: sda_low_d = !sh_q[7];
      S_RX_ACK:            sda_low_d = (cnt_q != '0);
      default:             sda_low_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  ph_q <= 2'd0;  qcnt_q <= QMAX;  bit_q <= 3'd7;
      sh_q <= '0;  buf_q <= '0;  reg_q <= '0;  addr_q <= '0;  cnt_q <= '0;
      rnw_q <= 1'b0;  use_reg_q <= 1'b0;  rs_done_q <= 1'b0;  ack_q <= 1'b0;
      nack_err_q <= 1'b0;  data_o_q <= '0;  data_valid_q <= 1'b0;  data_req_q <= 1'b0;
      scl_low_q <= 1'b0;  sda_low_q <= 1'b0;  scl_sync_q <= 2'b11;  sda_sync_q <= 2'b11;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;  qcnt_q <= qcnt_d;  bit_q <= bit_d;
      sh_q <= sh_d;  buf_q <= buf_d;  reg_q <= reg_d;  addr_q <= addr_d;  cnt_q <= cnt_d;
      rnw_q <= rnw_d;  use_reg_q <= use_reg_d;  rs_done_q <= rs_done_d;  ack_q <= ack_d;
      nack_err_q <= nack_err_d;  data_o_q <= data_o_d;  data_valid_q <= data_valid_d;
      data_req_q <= data_req_d;  scl_low_q <= scl_low_d;  sda_low_q <= sda_low_d;
      scl_sync_q <= scl_sync_d;  sda_sync_q <= sda_sync_d;
    end
  end

  assign SCL        = scl_low_q ? 1'b0 : 1'bz;
  assign SDA        = sda_low_q ? 1'b0 : 1'bz;
  assign ready      = (state_q == S_IDLE);
  assign data_req   = data_req_q;
  assign data_o     = data_o_q;
  assign data_valid = data_valid_q;
  assign nack_err   = nack_err_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst: bus monitor plus a simple slave model at 7'h55.
module tb_i2c_master_burst;
  localparam int EV_S = 32'h2000;
  localparam int EV_P = 32'h3000;

  logic       clk, rst, start, read_nwrite, use_reg;
  logic [6:0] addr;
  logic [7:0] reg_addr, data_i, data_o;
  logic [3:0] byte_count;
  logic       data_req, data_valid, ready, nack_err;
  wire        scl_w, sda_w;
  logic       scl_drv = 1'b0, sda_drv = 1'b0;

  pullup (scl_w);
  pullup (sda_w);
  assign scl_w = scl_drv ? 1'b0 : 1'bz;
  assign sda_w = sda_drv ? 1'b0 : 1'bz;

  i2c_master_burst #(.CLK_DIV(4), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .read_nwrite(read_nwrite), .use_reg(use_reg),
    .addr(addr), .reg_addr(reg_addr), .byte_count(byte_count), .data_i(data_i),
    .data_req(data_req), .data_o(data_o), .data_valid(data_valid), .ready(ready),
    .nack_err(nack_err), .SCL(scl_w), .SDA(sda_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0, n_fail = 0;
  int log_q[$], exp_q[$];
  logic [7:0] rxq[$], rdq[$], wq[$];
  int req_cnt = 0, lowcnt = 0, lowmax = 0;
  logic [6:0] slave_addr = 7'h55;
  bit stretch_en = 0;

  // Slave model and bus decoder, sampled on the falling clk edge.
  initial begin
    logic scl, sda, scl_p, sda_p, first_b, match_b, slave_tx;
    logic [7:0] srx, txb;
    int bitn, stretch_left;
    scl_p = 1'b1; sda_p = 1'b1; first_b = 1'b0; match_b = 1'b0; slave_tx = 1'b0;
    srx = 8'h00; txb = 8'hFF; bitn = -1; stretch_left = 0;
    forever begin
      @(negedge clk);
      scl = scl_w; sda = sda_w;
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) scl_drv = 1'b0;
      end
      if (scl && !scl_p) begin
        if (lowcnt > lowmax) lowmax = lowcnt;
        lowcnt = 0;
        if (bitn >= 0 && bitn < 8) srx = {srx[6:0], sda};
        else if (bitn == 8) begin
          log_q.push_back(32'h1000 | (int'(sda) << 8) | int'(srx));
          if (first_b) begin
            first_b = 1'b0;
            slave_tx = match_b && srx[0];
          end else if (slave_tx && sda) slave_tx = 1'b0;
        end
      end
      if (!scl && scl_p) begin
        bitn = (bitn == 8) ? 0 : bitn + 1;
        sda_drv = 1'b0;
        if (bitn == 8) begin
          if (!slave_tx) begin
            if (first_b) begin
              match_b = (srx[7:1] == slave_addr);
              sda_drv = match_b;
            end else sda_drv = 1'b1;
          end
        end else if (slave_tx) begin
          if (bitn == 0) txb = (rdq.size() > 0) ? rdq.pop_front() : 8'hFF;
          sda_drv = !txb[7-bitn];
        end
        if (first_b && bitn == 4 && stretch_en) begin
          scl_drv = 1'b1; stretch_left = 500;
        end
      end
      if (scl && scl_p && sda_p && !sda) begin
        log_q.push_back(EV_S); bitn = -1; first_b = 1'b1; slave_tx = 1'b0; sda_drv = 1'b0;
      end
      if (scl && scl_p && !sda_p && sda) begin
        log_q.push_back(EV_P); bitn = -1; slave_tx = 1'b0; sda_drv = 1'b0;
      end
      if (!scl) lowcnt++;
      scl_p = scl; sda_p = sda;
    end
  end

  // Handshake side: counts data_req, feeds the next write byte, collects reads.
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) rxq.push_back(data_o);
      if (data_req === 1'b1) begin
        req_cnt++;
        @(posedge clk); #1;
        if (wq.size() > 0) data_i = wq.pop_front();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) chk($sformatf("%s_ev%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic begin_xfer(input logic rnw, input logic ur, input logic [6:0] a,
                            input logic [7:0] ra, input logic [3:0] cnt);
    log_q.delete(); rxq.delete();
    req_cnt = 0; lowmax = 0; lowcnt = 0;
    read_nwrite = rnw; use_reg = ur; addr = a; reg_addr = ra; byte_count = cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ready_drop", ready, 1'b0);
  endtask

  task automatic finish_xfer();
    int n = 0;
    while (ready !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; read_nwrite = 1'b0; use_reg = 1'b0;
    addr = 7'h00; reg_addr = 8'h00; byte_count = 4'd0; data_i = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_scl", scl_w, 1'b1);
    chk("rst_sda", sda_w, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_nack_err", nack_err, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Two-byte write
    data_i = 8'h13; wq = {8'hCE};
    begin_xfer(1'b0, 1'b0, 7'h55, 8'h00, 4'd2);
    finish_xfer();
    exp_q = {EV_S, 32'h10AA, 32'h1013, 32'h10CE, EV_P};
    chk_log("wr");
    chk("wr_req_cnt", req_cnt, 2);
    chk("wr_nack_err", nack_err, 1'b0);
    chk("wr_scl_low_short", lowmax <= 12, 1'b1);

    // Combined read of three bytes through register 0x10
    rdq = {8'hA1, 8'hB2, 8'hC3};
    begin_xfer(1'b1, 1'b1, 7'h55, 8'h10, 4'd3);
    finish_xfer();
    exp_q = {EV_S, 32'h10AA, 32'h1010, EV_S, 32'h10AB, 32'h10A1, 32'h10B2, 32'h11C3, EV_P};
    chk_log("rd");
    chk("rd_valid_cnt", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("rd_byte0", rxq[0], 8'hA1);
      chk("rd_byte1", rxq[1], 8'hB2);
      chk("rd_byte2", rxq[2], 8'hC3);
    end
    chk("rd_data_o_held", data_o, 8'hC3);
    chk("rd_req_cnt", req_cnt, 0);
    chk("rd_nack_err", nack_err, 1'b0);

    // Absent target
    begin_xfer(1'b0, 1'b0, 7'h22, 8'h00, 4'd1);
    finish_xfer();
    exp_q = {EV_S, 32'h1144, EV_P};
    chk_log("nack");
    chk("nack_err_set", nack_err, 1'b1);
    chk("nack_req_cnt", req_cnt, 0);

    // Clock stretch after the 4th address bit; a stray start mid-transfer is ignored
    stretch_en = 1; data_i = 8'h5A;
    begin_xfer(1'b0, 1'b0, 7'h55, 8'h00, 4'd1);
    chk("nack_err_cleared", nack_err, 1'b0);
    repeat (40) @(posedge clk);
    #1 addr = 7'h22; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_xfer();
    stretch_en = 0;
    exp_q = {EV_S, 32'h10AA, 32'h105A, EV_P};
    chk_log("str");
    chk("str_low_min", lowmax >= 500, 1'b1);
    chk("str_low_max", lowmax <= 510, 1'b1);
    chk("str_nack_err", nack_err, 1'b0);

    // Address-only probe
    begin_xfer(1'b0, 1'b0, 7'h55, 8'h00, 4'd0);
    finish_xfer();
    exp_q = {EV_S, 32'h10AA, EV_P};
    chk_log("probe");
    chk("probe_ready", ready, 1'b1);
    chk("probe_req_cnt", req_cnt, 0);

    // Reset during the second data byte
    data_i = 8'h11; wq = {8'h22};
    begin_xfer(1'b0, 1'b0, 7'h55, 8'h00, 4'd2);
    n = 0;
    while (req_cnt < 2 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_second_req", req_cnt, 2);
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_scl", scl_w, 1'b1);
    chk("mid_rst_sda", sda_w, 1'b1);
    chk("mid_rst_ready", ready, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    data_i = 8'h77;
    begin_xfer(1'b0, 1'b0, 7'h55, 8'h00, 4'd1);
    finish_xfer();
    exp_q = {EV_S, 32'h10AA, 32'h1077, EV_P};
    chk_log("post_rst");
    chk("post_rst_req_cnt", req_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_burst.md
I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

Interface
REQ-001 Parameter CLK_DIV, default 125: clk cycles per SCL quarter-period; 100 kHz SCL at 50 MHz.
REQ-002 Parameter LEN_W, default 4: width of byte_count; a transfer is at most 2^LEN_W-1 bytes.
REQ-003 Port clk  in  1: single clock for all logic.
REQ-004 Port rst  in  1: reset, asynchronous and active-low.
REQ-005 Port start  in  1: request a transfer; sampled only in IDLE.
REQ-006 Port read_nwrite  in  1: 1 = read, 0 = write; latched at start.
REQ-007 Port use_reg  in  1: combined format (write reg_addr, then data phase); latched at start.
REQ-008 Port addr  in  7: 7-bit target address; latched at start.
REQ-009 Port reg_addr  in  8: register byte for combined format; latched at start.
REQ-010 Port byte_count  in  LEN_W: number of data bytes; latched at start.
REQ-011 Port data_i  in  8: write byte; sampled in the clk cycle where data_req=1.
REQ-012 Port data_req  out  1: one-cycle pulse requesting the next write byte.
REQ-013 Port data_o  out  8: last received byte; held until the next byte completes.
REQ-014 Port data_valid  out  1: one-cycle pulse when data_o updates.
REQ-015 Port ready  out  1: high in IDLE only.
REQ-016 Port nack_err  out  1: sticky error flag; set on an unexpected NACK; cleared by the next accepted start.
REQ-017 Port SCL  inout  1: open-drain; drive 0 or Z, never 1.
REQ-018 Port SDA  inout  1: open-drain; drive 0 or Z, never 1.

Function
REQ-019 Quarter tick: counter wraps every CLK_DIV clk cycles; each SCL bit is 4 quarters (low, low, high, high); SDA changes only in the first low quarter.
REQ-020 Clock stretching: while SCL is released and samples 0, the quarter counter SHALL hold.
REQ-021 States: IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, RSTART, TX, TX_ACK, RX, RX_ACK, STOP.
REQ-022 IDLE: on start=1, latch inputs, clear nack_err, and enter START; ready drops in the next cycle.
REQ-023 START: SDA falls while SCL is high.
REQ-024 ADDR: shift {addr, rw} MSB first.
REQ-025 rw = 0 if use_reg is set, otherwise read_nwrite.
REQ-026 ADDR_ACK: sample SDA at SCL high.
REQ-027 ADDR_ACK with SDA=1: set nack_err and go to STOP.
REQ-028 REG/REG_ACK: shift reg_addr and sample ACK; a NACK sets nack_err and goes to STOP.
REQ-029 After REG_ACK: if read_nwrite=1, go to RSTART, then resend addr with rw=1; otherwise go directly to TX.
REQ-030 RSTART: release SDA, raise SCL, then SDA falls while SCL is high.
REQ-031 TX: data_req pulses once per byte, before that byte's first SCL low quarter.
REQ-032 TX: data_i captured in the data_req cycle is shifted out MSB first.
REQ-033 TX_ACK: a NACK before the last byte sets nack_err and goes to STOP, skipping the remaining bytes.
REQ-034 TX_ACK: a NACK on the last byte is not an error.
REQ-035 RX: sample SDA at each SCL rising quarter; data_valid pulses once after bit 0 is sampled.
REQ-036 RX_ACK: the master drives ACK (0) for every byte except the last and releases SDA (NACK) for the last.
REQ-037 An internal byte counter decrements per data byte; at 0 the block goes to STOP.
REQ-038 byte_count=0: address-only probe; after ADDR_ACK (or REG_ACK) go directly to STOP with no data phase.
REQ-039 STOP: SDA rises while SCL is high; the block then returns to IDLE and ready=1.
REQ-040 start while not IDLE is ignored.
REQ-041 Bus never driven high; SCL/SDA are Z in IDLE.

Reset
REQ-042 rst=0 forces IDLE immediately (asynchronous).
REQ-043 Reset values: SCL=Z, SDA=Z, ready=1, data_req=0, data_valid=0, data_o=8'h00, nack_err=0.
REQ-044 Reset mid-transfer releases both lines at once; no STOP is generated.

Verification
REQ-045 Write: addr=7'h55, byte_count=2, data 8'h13/8'hCE, ACKing slave -> SDA bits 0xAA, 0x13, 0xCE; 2 data_req pulses; STOP; nack_err=0.
REQ-046 Combined read: use_reg=1, reg_addr=8'h10, read, byte_count=3, slave returns A1/B2/C3 -> bus shows 0xAA, 0x10, Sr, 0xAB; 3 data_valid pulses with A1, B2, C3; ACK,ACK,NACK; STOP.
REQ-047 No slave at 7'h22, byte_count=1 -> NACK on address, nack_err=1, STOP, no data_req.
REQ-048 Slave holds SCL low for 500 clk after the 4th address bit -> SCL high phase delayed 500 clk; byte content unchanged.
REQ-049 Probe with byte_count=0 -> START, 0xAA, ACK, STOP; ready=1 afterwards.
REQ-050 rst=0 during the 2nd data byte -> SCL=Z and SDA=Z within 1 clk; ready=1; the next start completes normally.
